// File: rtl/rca_share_arbiter.sv
// rtl/rca_share_arbiter.sv - round-robin sharing of one external ripple-carry adder
module rca_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int ADD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   A_in,
  input  logic [NUM_REQ*WIDTH-1:0]   B_in,
  input  logic [NUM_REQ-1:0]         C_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [WIDTH-1:0]           sum,
  output logic                       C_out,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic [WIDTH-1:0]           add_A,
  output logic [WIDTH-1:0]           add_B,
  output logic                       add_Cin,
  input  logic [WIDTH-1:0]           add_sum,
  input  logic                       add_Cout
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ADD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ADD_CYCLES - 1);
  localparam logic [OW-1:0] IDX_LAST = OW'(NUM_REQ - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t        state, state_d;
  logic [OW-1:0] ptr;
  logic [OW-1:0] win;
  logic [OW-1:0] ptr_nxt;
  logic [OW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          found;
  logic          start;
  logic          finish;
  int            pos;

  // Round-robin search: first requester at or after ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      idx = OW'(pos);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    ptr_nxt = (win == IDX_LAST) ? '0 : win + OW'(1);
  end

  assign start  = (state == IDLE) && found;
  assign finish = (state == ADD) && (cnt == CNT_LAST);
  assign busy   = (state == ADD);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state: leave IDLE on any request, return once the settle window ends.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (found)  state_d = ADD;
      ADD:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, grant/done pulses, settle counter and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= '0;
      done    <= '0;
      sum     <= '0;
      C_out   <= 1'b0;
      owner   <= '0;
      add_A   <= '0;
      add_B   <= '0;
      add_Cin <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      if (start) begin
        add_A   <= A_in[int'(win)*WIDTH +: WIDTH];
        add_B   <= B_in[int'(win)*WIDTH +: WIDTH];
        add_Cin <= C_in[win];
        owner   <= win;
        grant   <= NUM_REQ'(1) << win;
        cnt     <= '0;
        ptr     <= ptr_nxt;
      end
      if (state == ADD) begin
        cnt <= cnt + CW'(1);
        if (finish) begin
          sum   <= add_sum;
          C_out <= add_Cout;
          done  <= NUM_REQ'(1) << owner;
        end
      end
    end
  end

endmodule
